// File: rtl/cnn_loader_pkg.sv
// -----------------------------------------------------------------------------
// cnn_loader_pkg
// Shared definitions for the CNN stream loader:
//   state_t            - loader sequencing states
//   *_DEF localparams  - default weight/image sizes and result timeout
//   *_width functions  - counter widths derived from those sizes
// -----------------------------------------------------------------------------
package cnn_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_FILL,
        S_BURST,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam int WEIGHT_BYTES_DEF   = 54;   // 27 conv + 27 fully-connected
    localparam int DATA_BYTES_DEF     = 64;   // 8x8 image, raster order
    localparam int RESULT_TIMEOUT_DEF = 255;  // cycles from S_WAIT entry to give up

    // Weight counter must be able to hold 0..n.
    function automatic int wcnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Buffer pointer addresses 0..n-1.
    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Result timer must be able to hold 0..t.
    function automatic int timer_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/img_line_buf.sv
// -----------------------------------------------------------------------------
// img_line_buf
// Single-write / single-read synchronous image buffer (block RAM style).
// Contents are not reset. Read data appears one cycle after the address.
// Ports:
//   clk        in        clock
//   i_wr_en    in   1    write strobe
//   i_wr_addr  in   AW   write address
//   i_wr_data  in   8    write byte
//   i_rd_addr  in   AW   read address (sampled every cycle)
//   o_rd_data  out  8    registered read byte
// -----------------------------------------------------------------------------
module img_line_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cnn_stream_loader.sv
// -----------------------------------------------------------------------------
// cnn_stream_loader
// Host-side driver for the CNN accelerator. Weights from the host stream are
// forwarded one byte at a time; each image is buffered whole and then burst
// to the accelerator with no gaps (its window counter advances on every
// enabled cycle). The single result byte is returned over a valid/ready port.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s_data/s_valid/s_ready       host byte stream (slave)
//   reload_w                     sampled in S_IDLE: 1 = reload weights
//   acc_mode/acc_ram_en/acc_din  accelerator load port (1 = weight RAM)
//   acc_dout/acc_out_flag        accelerator result
//   m_data/m_valid/m_ready       result to host (master)
//   busy                         high outside S_IDLE
//   timeout_err                  sticky result-timeout flag
// -----------------------------------------------------------------------------
module cnn_stream_loader
    import cnn_loader_pkg::*;
#(
    parameter int WEIGHT_BYTES   = WEIGHT_BYTES_DEF,
    parameter int DATA_BYTES     = DATA_BYTES_DEF,
    parameter int RESULT_TIMEOUT = RESULT_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       reload_w,
    output logic       acc_mode,
    output logic       acc_ram_en,
    output logic [7:0] acc_din,
    input  logic [7:0] acc_dout,
    input  logic       acc_out_flag,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       busy,
    output logic       timeout_err
);

    localparam int WCNT_W = wcnt_width(WEIGHT_BYTES);
    localparam int PTR_W  = ptr_width(DATA_BYTES);
    localparam int TMR_W  = timer_width(RESULT_TIMEOUT);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_w_loaded;
    logic [WCNT_W-1:0] r_wcnt;
    logic [PTR_W-1:0]  r_ptr;
    logic [TMR_W-1:0]  r_timer;

    logic              r_wt_en;
    logic              r_wt_mode;
    logic [7:0]        r_wt_din;
    logic [7:0]        r_m_data;
    logic              r_m_valid;
    logic              r_timeout;

    logic              w_accept;
    logic              w_wt_accept;
    logic              w_wt_last;
    logic              w_fill_wr;
    logic              w_fill_last;
    logic              w_burst_last;
    logic              w_timer_expired;
    logic [PTR_W-1:0]  w_rd_addr;
    logic [7:0]        w_rd_data;

    assign s_ready         = (r_state == S_LOAD_W) || (r_state == S_FILL);
    assign w_accept        = s_valid && s_ready;
    assign w_wt_accept     = (r_state == S_LOAD_W) && w_accept;
    assign w_wt_last       = w_wt_accept && (r_wcnt == WCNT_W'(WEIGHT_BYTES - 1));
    assign w_fill_wr       = (r_state == S_FILL) && w_accept;
    assign w_fill_last     = w_fill_wr && (r_ptr == PTR_W'(DATA_BYTES - 1));
    assign w_burst_last    = (r_state == S_BURST) && (r_ptr == PTR_W'(DATA_BYTES - 1));
    // A flag on the final allowed cycle still wins over the timeout.
    assign w_timer_expired = (r_state == S_WAIT) && !acc_out_flag
                             && (r_timer == TMR_W'(RESULT_TIMEOUT - 1));

    // Read address runs one ahead of the burst pointer so the registered RAM
    // output lines up with r_ptr; address 0 is presented throughout S_FILL so
    // byte 0 is ready on the first burst cycle.
    always_comb begin
        w_rd_addr = '0;
        if (r_state == S_BURST && !w_burst_last) begin
            w_rd_addr = r_ptr + 1'b1;
        end
    end

    img_line_buf #(
        .DEPTH (DATA_BYTES),
        .AW    (PTR_W)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_fill_wr),
        .i_wr_addr (r_ptr),
        .i_wr_data (s_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = (reload_w || !r_w_loaded) ? S_LOAD_W : S_FILL;
            S_LOAD_W: if (w_wt_last)    w_state_next = S_FILL;
            S_FILL:   if (w_fill_last)  w_state_next = S_BURST;
            S_BURST:  if (w_burst_last) w_state_next = S_WAIT;
            S_WAIT: begin
                if (acc_out_flag) begin
                    w_state_next = S_HOLD;
                end else if (w_timer_expired) begin
                    w_state_next = S_IDLE;
                end
            end
            S_HOLD:   if (m_ready)      w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_loaded <= 1'b0;
            r_wcnt     <= '0;
            r_ptr      <= '0;
            r_timer    <= '0;
            r_wt_en    <= 1'b0;
            r_wt_mode  <= 1'b0;
            r_wt_din   <= '0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            // Weight bytes are forwarded with one cycle of latency. Mode
            // follows the strobe, so it only moves while the strobe is low or
            // together with a weight byte, and drops well before any burst.
            r_wt_en   <= w_wt_accept;
            r_wt_mode <= w_wt_accept;
            if (w_wt_accept) begin
                r_wt_din <= s_data;
            end

            case (r_state)
                S_LOAD_W: begin
                    if (w_wt_last) begin
                        r_wcnt     <= '0;
                        r_w_loaded <= 1'b1;
                    end else if (w_wt_accept) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_fill_last) begin
                        r_ptr <= '0;
                    end else if (w_fill_wr) begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                S_BURST: begin
                    r_ptr <= w_burst_last ? '0 : r_ptr + 1'b1;
                end
                default: begin
                    r_wcnt <= '0;
                    r_ptr  <= '0;
                end
            endcase

            if (r_state == S_WAIT) begin
                if (r_timer != '1) begin
                    r_timer <= r_timer + 1'b1;
                end
            end else begin
                r_timer <= '0;
            end

            if (r_state == S_WAIT && acc_out_flag) begin
                r_m_data  <= acc_dout;
                r_m_valid <= 1'b1;
            end else if (r_state == S_HOLD && m_ready) begin
                r_m_valid <= 1'b0;
            end

            if (w_timer_expired) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign acc_ram_en  = r_wt_en || (r_state == S_BURST);
    assign acc_mode    = r_wt_mode;
    assign acc_din     = (r_state == S_BURST) ? w_rd_data : r_wt_din;
    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_cnn_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_cnn_stream_loader
// Self-checking bench: a table of frame scenarios, hand-written corner
// sequences (timeout timing, mid-burst reset) and randomized frames checked
// against a frame-level model (expected accelerator write list, result byte,
// weight-loaded and sticky-timeout state).
// -----------------------------------------------------------------------------
module tb_cnn_stream_loader;

    localparam int WB = 54;
    localparam int DB = 64;
    localparam int RT = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       reload_w = 1'b0;
    logic       acc_mode;
    logic       acc_ram_en;
    logic [7:0] acc_din;
    logic [7:0] acc_dout = '0;
    logic       acc_out_flag = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       busy;
    logic       timeout_err;

    cnn_stream_loader dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .reload_w     (reload_w),
        .acc_mode     (acc_mode),
        .acc_ram_en   (acc_ram_en),
        .acc_din      (acc_din),
        .acc_dout     (acc_dout),
        .acc_out_flag (acc_out_flag),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Accelerator write log, sampled on the falling edge.
    typedef struct packed {
        logic [31:0] cyc;
        logic        mode;
        logic [7:0]  din;
    } wr_t;
    wr_t         wlog[$];
    logic [31:0] cyc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (acc_ram_en) begin
            wr_t e;
            e.cyc  = cyc;
            e.mode = acc_mode;
            e.din  = acc_din;
            wlog.push_back(e);
        end
    end

    // Frame payload and frame-level model state.
    logic [7:0] g_wts [WB];
    logic [7:0] g_dat [DB];
    bit         model_wl = 1'b0;
    bit         model_to = 1'b0;

    typedef struct {
        logic       reload;
        int         fdelay;   // WAIT cycle of first flag; -1 = never
        int         flen;
        logic [7:0] result;
        int         rdelay;
        bit         exp_w;
        bit         exp_to;
        logic [7:0] exp_md;
    } vec_t;
    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int count_data();
        int n = 0;
        foreach (wlog[i]) if (!wlog[i].mode) n++;
        return n;
    endfunction

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; reload_w = 1'b0;
        acc_dout = '0; acc_out_flag = 1'b0; m_ready = 1'b0;
        tick();
        tick();
        check("reset_outputs",
              {s_ready, acc_mode, acc_ram_en, acc_din, m_data, m_valid, busy, timeout_err}, 0);
        rst = 1'b0;
        model_wl = 1'b0;
        model_to = 1'b0;
    endtask

    task automatic fill_payload(input bit pattern, input int seed);
        for (int j = 0; j < WB; j++) g_wts[j] = pattern ? 8'(j + 1 + seed * 7) : 8'($urandom);
        for (int j = 0; j < DB; j++) g_dat[j] = pattern ? 8'(8'h40 + j + seed * 5) : 8'($urandom);
    endtask

    // Offer the byte stream with random gaps; counts bytes the DUT took.
    task automatic send_stream(input bit with_w, input bit flag_noise, output int accepted);
        logic [7:0] stream[$];
        int idx = 0;
        int guard = 0;
        bit acc;
        if (with_w) for (int j = 0; j < WB; j++) stream.push_back(g_wts[j]);
        for (int j = 0; j < DB; j++) stream.push_back(g_dat[j]);
        while (idx < stream.size() && guard < 4000) begin
            s_valid      = ($urandom_range(0, 3) != 0);
            s_data       = s_valid ? stream[idx] : 8'($urandom);
            acc_out_flag = flag_noise && ($urandom_range(0, 7) == 0);
            acc_dout     = 8'($urandom);
            acc = s_valid && s_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        s_valid = 1'b0;
        acc_out_flag = 1'b0;
        accepted = idx;
    endtask

    task automatic run_frame(input logic rl, input bit exp_w, input int fdelay, input int flen,
                             input logic [7:0] res, input int rdelay, input bit exp_to,
                             input logic [7:0] exp_md);
        int got, guard, bad_idx, exp_n, prev_c, first_d, last_w;
        bit sr_bad, mv_bad, st_bad, contig;
        logic te_before;

        reload_w = rl;
        wlog.delete();
        send_stream(exp_w, 1'b1, got);
        exp_n = (exp_w ? WB : 0) + DB;
        check("stream_accepted", got, exp_n);

        // Offer a byte during the burst; it must not be taken.
        guard = 0;
        sr_bad = 1'b0;
        s_valid = 1'b1;
        s_data = 8'hEE;
        while (!(count_data() == DB && !acc_ram_en) && guard < 400) begin
            if (acc_ram_en && !acc_mode && s_ready) sr_bad = 1'b1;
            tick();
            guard++;
        end
        s_valid = 1'b0;
        check("burst_completed", guard < 400, 1);
        check("burst_s_ready_low", sr_bad, 0);
        check("busy_in_wait", busy, 1);
        check("m_valid_at_wait_entry", m_valid, 0);

        bad_idx = -1;
        for (int i = 0; i < wlog.size() && i < exp_n; i++) begin
            logic       em;
            logic [7:0] ed;
            if (exp_w && i < WB) begin
                em = 1'b1; ed = g_wts[i];
            end else begin
                em = 1'b0; ed = g_dat[i - (exp_w ? WB : 0)];
            end
            if (bad_idx < 0 && (wlog[i].mode !== em || wlog[i].din !== ed)) bad_idx = i;
        end
        check("acc_write_count", wlog.size(), exp_n);
        check("acc_write_first_bad_index", bad_idx, -1);

        contig = 1'b1; prev_c = -1; first_d = -1; last_w = -1;
        foreach (wlog[i]) begin
            if (wlog[i].mode) begin
                last_w = int'(wlog[i].cyc);
            end else begin
                if (first_d < 0) first_d = int'(wlog[i].cyc);
                else if (int'(wlog[i].cyc) != prev_c + 1) contig = 1'b0;
                prev_c = int'(wlog[i].cyc);
            end
        end
        check("burst_contiguous", contig, 1);
        if (exp_w) check("mode_switch_gap", (first_d - last_w) >= 2, 1);

        mv_bad = 1'b0;
        if (fdelay >= 0) begin
            for (int k = 0; k < fdelay; k++) begin
                tick();
                if (m_valid) mv_bad = 1'b1;
            end
            check("m_valid_before_flag", mv_bad, 0);
            // Later flag cycles carry a different byte; only the first counts.
            for (int k = 0; k < flen; k++) begin
                acc_out_flag = 1'b1;
                acc_dout = (k == 0) ? res : ~res;
                tick();
            end
            acc_out_flag = 1'b0;
            check("m_valid_after_flag", m_valid, 1);
            check("m_data", m_data, exp_md);
            st_bad = 1'b0;
            for (int k = 0; k < rdelay; k++) begin
                tick();
                if (m_valid !== 1'b1 || m_data !== exp_md) st_bad = 1'b1;
            end
            check("m_hold_stable", st_bad, 0);
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            check("m_valid_after_accept", m_valid, 0);
            check("busy_after_accept", busy, 0);
        end else begin
            te_before = 1'b0;
            for (int k = 1; k <= RT; k++) begin
                tick();
                if (m_valid) mv_bad = 1'b1;
                if (k == RT - 1) te_before = timeout_err;
            end
            check("timeout_not_early", te_before, model_to);
            check("timeout_set", timeout_err, 1);
            check("busy_after_timeout", busy, 0);
            check("m_valid_never_on_timeout", mv_bad, 0);
        end
        check("timeout_err_end_of_frame", timeout_err, exp_to);

        if (exp_w) model_wl = 1'b1;
        model_to = exp_to;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, guard;
        int fd, fl, rd;
        logic rl;
        bit ew, et;
        logic [7:0] res;

        //          reload fdelay flen result rdelay exp_w exp_to exp_md
        vecs[0] = '{1'b0,  10,    3,   8'h5A, 20,    1'b1, 1'b0,  8'h5A};
        vecs[1] = '{1'b0,  0,     1,   8'hA5, 0,     1'b0, 1'b0,  8'hA5};
        vecs[2] = '{1'b1,  254,   1,   8'h3C, 2,     1'b1, 1'b0,  8'h3C};
        vecs[3] = '{1'b0,  -1,    1,   8'h00, 0,     1'b0, 1'b1,  8'h00};
        vecs[4] = '{1'b0,  5,     2,   8'h81, 1,     1'b0, 1'b1,  8'h81};

        do_reset();

        for (int i = 0; i < 5; i++) begin
            fill_payload(1'b1, i);
            run_frame(vecs[i].reload, vecs[i].exp_w, vecs[i].fdelay, vecs[i].flen,
                      vecs[i].result, vecs[i].rdelay, vecs[i].exp_to, vecs[i].exp_md);
        end

        // Sticky timeout clears only on reset (reset check covers timeout_err).
        do_reset();

        // Load weights, then reset in the middle of the next image's burst.
        fill_payload(1'b0, 0);
        run_frame(1'b0, 1'b1, 3, 1, 8'h11, 0, 1'b0, 8'h11);
        fill_payload(1'b0, 0);
        reload_w = 1'b0;
        wlog.delete();
        send_stream(1'b0, 1'b0, got);
        check("midburst_stream_accepted", got, DB);
        guard = 0;
        while (count_data() < 30 && guard < 200) begin
            tick();
            guard++;
        end
        check("midburst_reached_byte30", count_data(), 30);
        check("midburst_byte30_on_bus", {acc_ram_en, acc_mode, acc_din}, {1'b1, 1'b0, g_dat[30]});
        rst = 1'b1;
        tick();
        check("midburst_reset_outputs",
              {s_ready, acc_mode, acc_ram_en, acc_din, m_data, m_valid, busy, timeout_err}, 0);
        rst = 1'b0;
        model_wl = 1'b0;
        model_to = 1'b0;
        // Weights were forgotten, so even with reload_w=0 a weight phase follows.
        fill_payload(1'b0, 0);
        run_frame(1'b0, 1'b1, 7, 2, 8'hC3, 3, 1'b0, 8'hC3);

        // Randomized frames against the frame-level model.
        for (int n = 0; n < 12; n++) begin
            fill_payload(1'b0, 0);
            rl  = ($urandom_range(0, 3) == 0);
            fd  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 40));
            fl  = int'($urandom_range(1, 3));
            rd  = int'($urandom_range(0, 6));
            res = 8'($urandom);
            ew  = rl || !model_wl;
            et  = model_to || (fd < 0);
            run_frame(rl, ew, fd, fl, res, rd, et, res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
